// File: rtl/stdout_uart_tx.sv
// Brainfuck core output stage: captures stdout bytes into a FIFO and
// serialises them as 8N1 UART frames with cts_n flow control.
module stdout_uart_tx #(
  parameter int CLKS_PER_BIT = 104,
  parameter int FIFO_DEPTH   = 16,
  parameter int CNT_WIDTH    = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [7:0]           stdout_data,
  input  logic                 stdout_en,
  input  logic                 cts_n,
  output logic                 cpu_en,
  output logic                 tx,
  output logic                 busy,
  output logic                 overflow,
  output logic [CNT_WIDTH-1:0] fifo_count
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int BW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  logic [7:0]           mem [FIFO_DEPTH];
  logic [PW-1:0]        wr_ptr;
  logic [PW-1:0]        rd_ptr;
  logic [CNT_WIDTH-1:0] count;
  logic                 prev_en;
  logic                 capture;
  logic                 full;
  logic                 wr;
  logic                 pop;
  logic                 can_start;
  logic                 last_baud;

  state_t               state;
  state_t               state_n;
  logic [BW-1:0]        baud;
  logic [BW-1:0]        baud_n;
  logic [2:0]           bit_idx;
  logic [2:0]           bit_n;
  logic [7:0]           shreg;
  logic [7:0]           shreg_n;
  logic                 tx_r;
  logic                 tx_n;

  // Only the rising edge counts: a halted core may hold stdout_en high.
  assign capture   = stdout_en && !prev_en;
  assign full      = count == CNT_WIDTH'(FIFO_DEPTH);
  assign wr        = capture && !full;
  assign can_start = (count != '0) && !cts_n;
  assign last_baud = baud == BW'(CLKS_PER_BIT - 1);

  assign cpu_en     = count < CNT_WIDTH'(FIFO_DEPTH - 1);
  assign busy       = (state != IDLE) || (count != '0);
  assign fifo_count = count;
  assign tx         = tx_r;

  always_ff @(posedge clk) begin
    if (wr) mem[wr_ptr] <= stdout_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prev_en  <= 1'b0;
      overflow <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
    end else begin
      prev_en <= stdout_en;
      if (capture && full) overflow <= 1'b1;
      if (wr) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (wr && !pop) count <= count + 1'b1;
      else if (pop && !wr) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      baud    <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      tx_r    <= 1'b1;
    end else begin
      state   <= state_n;
      baud    <= baud_n;
      bit_idx <= bit_n;
      shreg   <= shreg_n;
      tx_r    <= tx_n;
    end
  end

  always_comb begin
    state_n = state;
    baud_n  = baud + 1'b1;
    bit_n   = bit_idx;
    shreg_n = shreg;
    tx_n    = tx_r;
    pop     = 1'b0;
    unique case (state)
      IDLE: begin
        baud_n = '0;
        tx_n   = 1'b1;
        if (can_start) begin
          pop     = 1'b1;
          shreg_n = mem[rd_ptr];
          tx_n    = 1'b0;
          state_n = START;
        end
      end
      START: begin
        if (last_baud) begin
          baud_n  = '0;
          bit_n   = '0;
          tx_n    = shreg[0];
          state_n = DATA;
        end
      end
      DATA: begin
        if (last_baud) begin
          baud_n = '0;
          if (bit_idx == 3'd7) begin
            tx_n    = 1'b1;
            state_n = STOP;
          end else begin
            shreg_n = shreg >> 1;
            tx_n    = shreg[1];
            bit_n   = bit_idx + 3'd1;
          end
        end
      end
      STOP: begin
        if (last_baud) begin
          baud_n = '0;
          // Chain straight into the next start bit when data is waiting.
          if (can_start) begin
            pop     = 1'b1;
            shreg_n = mem[rd_ptr];
            tx_n    = 1'b0;
            state_n = START;
          end else begin
            state_n = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule
